regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port (we3/a3/wd3) between the core writeback path and an auxiliary requester such as a debug or program loader. The core writeback has fixed priority, and a starvation limit forces one auxiliary slot by stalling the core for a cycle. After reset, an optional clear sequencer zeroes x1–x31 before normal operation. The block sits between the core datapath and `regfile`.

## Interface
Parameters:
- `CLEAR_ON_RESET`, default 1: 1 runs the x1–x31 zeroing sequence after reset; 0 goes directly to RUN.
- `STARVE_LIMIT`, default 4: number of consecutive denied auxiliary cycles before a forced grant; 0 disables forcing.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `core_we`  in  1  core writeback enable (RegWrite).
- `core_waddr`  in  5  core destination register.
- `core_wdata`  in  32  core writeback data.
- `core_stall`  out  1  core must hold PC and its writeback this cycle.
- `dbg_valid`  in  1  auxiliary write request.
- `dbg_ready`  out  1  auxiliary write accepted this cycle.
- `dbg_addr`  in  5  auxiliary destination register.
- `dbg_wdata`  in  32  auxiliary write data.
- `rf_we3`  out  1  to `regfile` we3.
- `rf_a3`  out  5  to `regfile` a3.
- `rf_wd3`  out  32  to `regfile` wd3.
- `init_done`  out  1  high once in RUN.

## Operation
- States: CLEAR, RUN.
  - Reset enters CLEAR if `CLEAR_ON_RESET` is 1, otherwise RUN.
- CLEAR:
  - `clr_idx` starts at 1 and drives `rf_we3`=1, `rf_a3`=`clr_idx`, `rf_wd3`=0.
  - `clr_idx` increments each cycle. After writing index 31, the block enters RUN. CLEAR lasts 31 cycles.
  - Throughout CLEAR: `core_stall`=1, `dbg_ready`=0, `init_done`=0.
- RUN: `init_done`=1.
  - A core write is live when `core_we`=1 and `core_waddr`≠0.
  - `force` = (`STARVE_LIMIT`≠0) && `dbg_valid` && (`wait_cnt` ≥ `STARVE_LIMIT`).
  - `force`=1: `core_stall`=1, `dbg_ready`=1, and the port carries the auxiliary write. The core write is suppressed; the core re-presents it next cycle.
  - Else, if a core write is live: the port carries the core write, `dbg_ready`=0, `core_stall`=0.
  - Else: `dbg_ready`=`dbg_valid`, `core_stall`=0, and the port carries the auxiliary write when `dbg_valid`=1.
  - Writes to x0 from either source drive `rf_we3`=0. A handshake still completes for an auxiliary x0 request.
  - No write: `rf_we3`=0, `rf_a3`=0, `rf_wd3`=0.
- `wait_cnt`:
  - Width `$clog2(STARVE_LIMIT+1)` (minimum 1), saturating.
  - Increments when `dbg_valid` && !`dbg_ready` in RUN.
  - Clears on a handshake or when `dbg_valid`=0.
  - Held at 0 in CLEAR.
- Auxiliary protocol: once `dbg_valid` is raised, `dbg_addr` and `dbg_wdata` stay stable until the handshake.

## Timing
- All `rf_*`, `core_stall` and `dbg_ready` outputs are combinational from state and inputs.
  - Zero-latency grant: the write lands at the clock edge that ends the granted cycle.
- Reset values while `rst_n`=0:
  - `rf_we3`=0, `rf_a3`=0, `rf_wd3`=0 (gated by `rst_n`).
  - `core_stall`=1, `dbg_ready`=0, `init_done`=0.
- Internal reset values: state=CLEAR (or RUN), `clr_idx`=1, `wait_cnt`=0.
- Reset asserted mid-CLEAR or mid-RUN aborts immediately. The sequence restarts from x1 after release.
- First RUN cycle follows 31 cycles after `rst_n` rises with `CLEAR_ON_RESET`=1, or 0 cycles with it set to 0.
- A forced grant lasts exactly one cycle. After it, `wait_cnt`=0, so the core keeps priority for at least `STARVE_LIMIT` cycles before the next force.
- Simultaneous live core write and `dbg_valid` with `wait_cnt`<limit: the core wins.

## Structure
- Package `rf_arb_pkg`:
  - `typedef enum logic {CLEAR, RUN} rf_arb_state_t`.
  - `localparam NUM_REGS=32`, `ADDR_W=5`, `DATA_W=32`.
- Sub-module `rf_clear_sequencer`: owns `clr_idx` and the CLEAR→RUN done flag, and outputs clear address plus active flag.
- Arbitration and `wait_cnt` live in the top module.

## Test plan
- Reset release, `CLEAR_ON_RESET`=1 → `rf_we3`=1 with `rf_a3`=1..31 and `rf_wd3`=0 on cycles 0–30; `init_done`=1 on cycle 31; `core_stall`=1 until then.
- RUN: `core_we`=1, `core_waddr`=5, `core_wdata`=0xDEAD, and `dbg_valid`=1 in the same cycle → `rf_a3`=5, `rf_wd3`=0xDEAD, `dbg_ready`=0.
- `STARVE_LIMIT`=4, continuous core writes to x7, `dbg_valid`=1 with `dbg_addr`=9, `dbg_wdata`=0x1234 → cycles 0–3 carry the core write; cycle 4 has `core_stall`=1, `dbg_ready`=1, `rf_a3`=9, `rf_wd3`=0x1234; cycle 5 returns to the core.
- `core_we`=1 with `core_waddr`=0 and `dbg_valid`=1 with `dbg_addr`=3 → `dbg_ready`=1, auxiliary write to x3, no core write.
- `dbg_addr`=0, `dbg_valid`=1, core idle → `dbg_ready`=1, `rf_we3`=0.
- `rst_n` asserted at CLEAR index 12 → outputs go immediately to reset values; after release the sequence restarts at `rf_a3`=1 and completes 31 writes.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package rf_arb_pkg;

    typedef enum logic {CLEAR, RUN} rf_arb_state_t;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

endpackage

// File: rtl/rf_clear_sequencer.sv
// Post-reset sequencer that walks x1..x31 once so the register file starts
// zeroed, then reports completion. With CLEAR_ON_RESET=0 it starts done.
module rf_clear_sequencer
    import rf_arb_pkg::*;
#(
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_active,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);

    localparam rf_arb_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    rf_arb_state_t     state_q, state_d;
    logic [ADDR_W-1:0] clr_idx, clr_idx_d;

    // State and clear-index registers; reset restarts the walk from x1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            clr_idx <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            clr_idx <= clr_idx_d;
        end
    end

    // Advance one register per cycle; leave CLEAR after writing the last index.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx;
        if (state_q == CLEAR) begin
            if (clr_idx == LAST_IDX) begin
                state_d   = RUN;
                clr_idx_d = FIRST_IDX;
            end else begin
                clr_idx_d = clr_idx + ADDR_W'(1);
            end
        end
    end

    assign clr_active = (state_q == CLEAR);
    assign done       = (state_q == RUN);
    assign clr_addr   = clr_idx;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between core writeback (priority) and
// an auxiliary requester. A starvation counter forces one auxiliary slot by
// stalling the core for a single cycle. All port outputs are combinational.
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int CLEAR_ON_RESET = 1,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              rf_we3,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              init_done
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              seq_active, seq_done;
    logic [ADDR_W-1:0] seq_addr;
    logic              run_mode, clr_mode;
    logic              core_live, force_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rf_clear_sequencer #(
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_active (seq_active),
        .clr_addr   (seq_addr),
        .done       (seq_done)
    );

    // Gate by rst_n so the port is quiet and the core held while in reset.
    assign run_mode    = rst_n && seq_done;
    assign clr_mode    = rst_n && seq_active;
    assign core_live   = core_we && (core_waddr != '0);
    assign force_grant = (STARVE_LIMIT != 0) && dbg_valid && (wait_cnt >= LIMIT);

    // Source selection: forced aux slot, else core, else aux; clear owns the port in CLEAR.
    always_comb begin
        core_stall = 1'b1;
        dbg_ready  = 1'b0;
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        if (run_mode) begin
            core_stall = 1'b0;
            if (force_grant) begin
                core_stall = 1'b1;
                dbg_ready  = 1'b1;
                sel_we     = 1'b1;
                sel_addr   = dbg_addr;
                sel_data   = dbg_wdata;
            end else if (core_live) begin
                sel_we   = 1'b1;
                sel_addr = core_waddr;
                sel_data = core_wdata;
            end else if (dbg_valid) begin
                dbg_ready = 1'b1;
                sel_we    = 1'b1;
                sel_addr  = dbg_addr;
                sel_data  = dbg_wdata;
            end
        end else if (clr_mode) begin
            sel_we   = 1'b1;
            sel_addr = seq_addr;
            sel_data = '0;
        end
    end

    // x0 is never written; an idle port drives all-zero address and data.
    assign rf_we3    = sel_we && (sel_addr != '0);
    assign rf_a3     = rf_we3 ? sel_addr : '0;
    assign rf_wd3    = rf_we3 ? sel_data : '0;
    assign init_done = run_mode;

    // Count consecutive denied auxiliary cycles, saturating; cleared on grant or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!run_mode || !dbg_valid || dbg_ready) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (CLEAR_ON_RESET=1, STARVE_LIMIT=4).
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_we;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        init_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .CLEAR_ON_RESET(1),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .rf_we3     (rf_we3),
        .rf_a3      (rf_a3),
        .rf_wd3     (rf_wd3),
        .init_done  (init_done)
    );

    typedef struct {
        string       name;
        logic        cwe;
        logic [4:0]  caddr;
        logic [31:0] cdata;
        logic        dvalid;
        logic [4:0]  daddr;
        logic [31:0] ddata;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[7];

    // Output bundle: {stall, ready, we3, a3, wd3, init_done}
    task automatic check(input string name, input logic [40:0] exp);
        logic [40:0] got;
        got = {core_stall, dbg_ready, rf_we3, rf_a3, rf_wd3, init_done};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got stall=%b ready=%b we=%b a3=%0d wd=%h init=%b, expected stall=%b ready=%b we=%b a3=%0d wd=%h init=%b",
                     name, got[40], got[39], got[38], got[37:33], got[32:1], got[0],
                     exp[40], exp[39], exp[38], exp[37:33], exp[32:1], exp[0]);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic cwe, input logic [4:0] ca, input logic [31:0] cd,
                          input logic dv, input logic [4:0] da, input logic [31:0] dd);
        core_we = cwe; core_waddr = ca; core_wdata = cd;
        dbg_valid = dv; dbg_addr = da; dbg_wdata = dd;
    endtask

    // Checks n consecutive CLEAR cycles starting at x1, advancing one edge each.
    task automatic clear_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s_idx%0d", tag, i + 1), {1'b1, 1'b0, 1'b1, 5'(i + 1), 32'h0, 1'b0});
            next_cycle();
        end
    endtask

    initial begin
        vecs[0] = '{"core_beats_dbg",   1, 5'd5,  32'h0000DEAD, 1, 5'd3, 32'h11, 0, 0, 1, 5'd5,  32'h0000DEAD};
        vecs[1] = '{"dbg_when_idle",    0, 5'd5,  32'h0000DEAD, 1, 5'd3, 32'h11, 0, 1, 1, 5'd3,  32'h11};
        vecs[2] = '{"core_x0_dbg_wins", 1, 5'd0,  32'h0000BEEF, 1, 5'd3, 32'h22, 0, 1, 1, 5'd3,  32'h22};
        vecs[3] = '{"dbg_x0_handshake", 0, 5'd0,  32'h0,        1, 5'd0, 32'h33, 0, 1, 0, 5'd0,  32'h0};
        vecs[4] = '{"core_x0_alone",    1, 5'd0,  32'h0000BEEF, 0, 5'd6, 32'h44, 0, 0, 0, 5'd0,  32'h0};
        vecs[5] = '{"core_x31",         1, 5'd31, 32'hFFFFFFFF, 0, 5'd6, 32'h44, 0, 0, 1, 5'd31, 32'hFFFFFFFF};
        vecs[6] = '{"all_idle",         0, 5'd8,  32'h5,        0, 5'd6, 32'h44, 0, 0, 0, 5'd0,  32'h0};

        rst_n = 1'b0;
        set_in(1, 5'd5, 32'hDEAD, 1, 5'd3, 32'h55);
        #1;
        check("reset_values", {1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full clear sequence with both requesters active; dbg must not accumulate wait.
        clear_cycles("clear", 31);
        #1;
        check("run_entry_core_wins", {1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b1});
        next_cycle();

        // Single-cycle arbitration vectors.
        for (int v = 0; v < 7; v++) begin
            set_in(vecs[v].cwe, vecs[v].caddr, vecs[v].cdata,
                   vecs[v].dvalid, vecs[v].daddr, vecs[v].ddata);
            #1;
            check(vecs[v].name, {vecs[v].e_stall, vecs[v].e_ready, vecs[v].e_we,
                                 vecs[v].e_a3, vecs[v].e_wd, 1'b1});
            next_cycle();
        end

        // Starvation: force on cycles 4 and 9, core everywhere else.
        set_in(1, 5'd7, 32'h700, 1, 5'd9, 32'h1234);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 4 || i == 9)
                check($sformatf("starve_c%0d", i), {1'b1, 1'b1, 1'b1, 5'd9, 32'h1234, 1'b1});
            else
                check($sformatf("starve_c%0d", i), {1'b0, 1'b0, 1'b1, 5'd7, 32'h700, 1'b1});
            next_cycle();
        end

        // Reset during CLEAR at index 12, then a full restart.
        set_in(1, 5'd5, 32'hDEAD, 1, 5'd3, 32'h55);
        rst_n = 1'b0;
        #1;
        check("rerun_reset", {1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0});
        next_cycle();
        rst_n = 1'b1;
        clear_cycles("pre_abort", 11);
        #1;
        check("abort_at_idx12", {1'b1, 1'b0, 1'b1, 5'd12, 32'h0, 1'b0});
        rst_n = 1'b0;
        #1;
        check("abort_reset_values", {1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0});
        next_cycle();
        rst_n = 1'b1;
        clear_cycles("restart", 31);
        #1;
        check("restart_run_entry", {1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
